// File: rtl/b2b_link_arbiter.sv
// Round-robin owner sequencer for a shared back-to-back link; data passes through untouched.
// Optional idle-owner timeout release is enabled by defining B2B_ARB_TIMEOUT_EN.
module b2b_link_arbiter #(
  parameter int unsigned NUM_AGENTS     = 2,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned MAX_BURST      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned SRC_W         = (NUM_AGENTS > 2) ? $clog2(NUM_AGENTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_AGENTS-1:0]        req_valid,
  input  logic [NUM_AGENTS*DATA_W-1:0] req_data,
  input  logic [NUM_AGENTS-1:0]        req_last,
  output logic [NUM_AGENTS-1:0]        req_ready,
  output logic                         link_valid,
  output logic [DATA_W-1:0]            link_data,
  output logic                         link_last,
  output logic [SRC_W-1:0]             link_src,
  input  logic                         link_ready,
  output logic [NUM_AGENTS-1:0]        grant,
  output logic                         timeout_err
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_AGENTS-1:0]   r_grant, w_grant_nxt;
  logic [SRC_W-1:0]        r_src, w_src_nxt;
  logic [SRC_W-1:0]        r_last_grant, w_last_grant_nxt;
  logic [7:0]              r_beat_cnt, w_beat_cnt_nxt;
  logic [SRC_W-1:0]        w_pick;
  logic                    w_owner_valid;
  logic                    w_owner_last;
  logic                    w_beat;
  logic                    w_release;
  logic                    w_timeout;
  logic [DATA_W-1:0]       w_link_data;

  // First requester at or after last_grant+1, wrapping.
  function automatic logic [SRC_W-1:0] f_next_owner(input logic [NUM_AGENTS-1:0] valid,
                                                    input logic [SRC_W-1:0]      last);
    logic [SRC_W-1:0] pick;
    logic             found;
    int unsigned      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_AGENTS; k++) begin
      cand = (32'(last) + k) % NUM_AGENTS;
      if (!found && valid[SRC_W'(cand)]) begin
        pick  = SRC_W'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick        = f_next_owner(req_valid, r_last_grant);
  assign w_owner_valid = |(req_valid & r_grant);
  assign w_owner_last  = |(req_last & r_grant);
  assign w_beat        = w_owner_valid & link_ready;
  assign w_release     = w_beat & (w_owner_last | (r_beat_cnt == 8'(MAX_BURST - 1)));

  // Owner data mux; grant is zero in IDLE so the link reads as 0 there.
  always_comb begin
    w_link_data = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      w_link_data = w_link_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{r_grant[i]}});
    end
  end

`ifdef B2B_ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;

  assign w_timeout   = (r_state == ST_BUSY) && (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_src_nxt        = r_src;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
`ifdef B2B_ARB_TIMEOUT_EN
    w_idle_cnt_nxt    = '0;
    w_timeout_err_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_state_nxt      = ST_BUSY;
          w_grant_nxt      = NUM_AGENTS'(1) << w_pick;
          w_src_nxt        = w_pick;
          w_last_grant_nxt = w_pick;
          w_beat_cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        if (w_release || w_timeout) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
        end else begin
          if (w_beat) begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          end
`ifdef B2B_ARB_TIMEOUT_EN
          w_idle_cnt_nxt = w_owner_valid ? '0 : r_idle_cnt + IDLE_W'(1);
`endif
        end
`ifdef B2B_ARB_TIMEOUT_EN
        w_timeout_err_nxt = w_timeout;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_src         <= '0;
      r_last_grant  <= SRC_W'(NUM_AGENTS - 1);
      r_beat_cnt    <= '0;
`ifdef B2B_ARB_TIMEOUT_EN
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_src         <= w_src_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
`ifdef B2B_ARB_TIMEOUT_EN
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
`endif
    end
  end

  assign grant      = r_grant;
  assign link_src   = r_src;
  assign link_valid = w_owner_valid;
  assign link_last  = w_owner_last;
  assign link_data  = w_link_data;
  assign req_ready  = r_grant & {NUM_AGENTS{link_ready}};

endmodule
